// File: rtl/rng_checker.sv
// Self-synchronising integrity monitor for the random-note generator: predicts each
// (LFSR word, note) pair from the previous one, locks on a clean run, flags mismatches.
module rng_checker #(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      word_in,
  input  logic [5:0]       note_in,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} mode_e;

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  function automatic logic [15:0] next_word(input logic [15:0] w);
    return {w[14:0], ~(w[10] ^ w[12] ^ w[13] ^ w[15])};
  endfunction

  // The note inversion is keyed on the MSB of the word that precedes it.
  function automatic logic [5:0] next_note(input logic [15:0] w, input logic [5:0] n);
    logic [5:0] base;
    base = {n[4:0], ~(n[3] ^ n[4] ^ n[5])};
    return w[15] ? ~base : base;
  endfunction

  mode_e            mode_q;
  logic [15:0]      mw_q;
  logic [5:0]       mn_q;
  logic             have_prev_q;
  logic [3:0]       good_run_q;
  logic [3:0]       bad_run_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             sync_loss_q;
  logic [CNT_W-1:0] err_count_q;

  logic [15:0]      pred_w;
  logic [5:0]       pred_n;
  logic             sample_good;
  logic [3:0]       good_run_d;
  logic [3:0]       bad_run_d;
  logic [CNT_W-1:0] err_count_d;

  always_comb begin
    pred_w      = next_word(mw_q);
    pred_n      = next_note(mw_q, mn_q);
    sample_good = (word_in == pred_w) && (note_in == pred_n);
    good_run_d  = good_run_q + 4'd1;
    bad_run_d   = bad_run_q + 4'd1;
    err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= SEARCH;
      mw_q        <= 16'h0000;
      mn_q        <= 6'h00;
      have_prev_q <= 1'b0;
      good_run_q  <= 4'd0;
      bad_run_q   <= 4'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      sync_loss_q <= 1'b0;
      if (en) begin
        case (mode_q)
          SEARCH: begin
            // In search the model always follows the inputs, good or bad.
            mw_q <= word_in;
            mn_q <= note_in;
            if (!have_prev_q) begin
              have_prev_q <= 1'b1;
            end else if (sample_good) begin
              if (good_run_d == LOCK_T) begin
                mode_q     <= LOCKED;
                locked_q   <= 1'b1;
                good_run_q <= 4'd0;
                bad_run_q  <= 4'd0;
              end else begin
                good_run_q <= good_run_d;
              end
            end else begin
              good_run_q <= 4'd0;
            end
          end
          LOCKED: begin
            if (sample_good) begin
              mw_q      <= pred_w;
              mn_q      <= pred_n;
              bad_run_q <= 4'd0;
            end else begin
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
              if (bad_run_d == LOSS_T) begin
                mode_q      <= SEARCH;
                locked_q    <= 1'b0;
                sync_loss_q <= 1'b1;
                mw_q        <= word_in;
                mn_q        <= note_in;
                good_run_q  <= 4'd0;
                bad_run_q   <= 4'd0;
              end else begin
                mw_q      <= pred_w;
                mn_q      <= pred_n;
                bad_run_q <= bad_run_d;
              end
            end
          end
          default: begin
            mode_q      <= SEARCH;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
            good_run_q  <= 4'd0;
            bad_run_q   <= 4'd0;
          end
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign sync_loss = sync_loss_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_rng_checker.sv
// Directed bench for rng_checker: lock, error flagging, loss/relock, en gaps,
// reset while locked, and counter saturation on a CNT_W=2 instance.
module tb_rng_checker;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] word;
  logic [5:0]  note;

  logic        locked, err_pulse, sync_loss;
  logic [15:0] err_count;
  logic        s_locked, s_err_pulse, s_sync_loss;
  logic [1:0]  s_err_count;

  int n_checks;
  int n_err;

  logic [15:0] gw;
  logic [5:0]  gn;

  rng_checker dut (
    .clk(clk), .rst(rst), .en(en), .word_in(word), .note_in(note),
    .locked(locked), .err_pulse(err_pulse), .sync_loss(sync_loss), .err_count(err_count)
  );

  rng_checker #(.LOCK_THRESH(4), .LOSS_THRESH(15), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .word_in(word), .note_in(note),
    .locked(s_locked), .err_pulse(s_err_pulse), .sync_loss(s_sync_loss),
    .err_count(s_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Generator step, used only to produce stimulus.
  task automatic advance();
    logic [5:0] base;
    base = {gn[4:0], ~(gn[3] ^ gn[4] ^ gn[5])};
    gn   = gw[15] ? ~base : base;
    gw   = {gw[14:0], ~(gw[10] ^ gw[12] ^ gw[13] ^ gw[15])};
  endtask

  task automatic send(input logic e, input logic [15:0] w, input logic [5:0] n);
    @(negedge clk);
    en   = e;
    word = w;
    note = n;
    @(posedge clk);
    #1;
  endtask

  task automatic send_good();
    send(1'b1, gw, gn);
    advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst  = 1'b1;
    en   = 1'b0;
    word = 16'h0000;
    note = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_sync_loss", 32'(sync_loss), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // Lock on the correct stream starting at (A455,2D) -> (48AA,24) -> ...
    gw = 16'hA455;
    gn = 6'h2D;
    send_good();
    chk("second_pair_word", 32'(gw), 32'h48AA);
    for (int i = 2; i <= 5; i++) begin
      send_good();
      chk("lock_latency", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("lock_err_count", 32'(err_count), 32'd0);
    chk("lock_err_pulse", 32'(err_pulse), 32'd0);
    chk("sat_locked", 32'(s_locked), 32'd1);

    // Word corrupted to zero, idle gap, then the stream resumes.
    send(1'b1, 16'h0000, gn);
    advance();
    chk("wcorr_err_pulse", 32'(err_pulse), 32'd1);
    chk("wcorr_err_count", 32'(err_count), 32'd1);
    chk("wcorr_locked", 32'(locked), 32'd1);
    chk("wcorr_sync_loss", 32'(sync_loss), 32'd0);
    send(1'b0, 16'hFFFF, 6'h3F);
    chk("idle_err_pulse", 32'(err_pulse), 32'd0);
    chk("idle_err_count", 32'(err_count), 32'd1);
    send_good();
    chk("resume1_err_pulse", 32'(err_pulse), 32'd0);
    chk("resume1_locked", 32'(locked), 32'd1);
    send_good();
    chk("resume2_err_pulse", 32'(err_pulse), 32'd0);
    chk("resume2_err_count", 32'(err_count), 32'd1);

    // Correct word with wrong note must be judged bad.
    send(1'b1, gw, gn ^ 6'h01);
    advance();
    chk("ncorr_err_pulse", 32'(err_pulse), 32'd1);
    chk("ncorr_err_count", 32'(err_count), 32'd2);
    send_good();
    chk("ncorr_after_pulse", 32'(err_pulse), 32'd0);
    chk("ncorr_after_locked", 32'(locked), 32'd1);

    // Three consecutive bad samples drop lock on the third.
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, 16'h0000, 6'h00);
      advance();
      chk("loss_err_pulse", 32'(err_pulse), 32'd1);
      chk("loss_sync_loss", 32'(sync_loss), (i == 3) ? 32'd1 : 32'd0);
      chk("loss_locked", 32'(locked), (i == 3) ? 32'd0 : 32'd1);
    end
    chk("loss_err_count", 32'(err_count), 32'd5);

    // Relock: first sample mismatches the reseeded model, then four good.
    for (int i = 1; i <= 5; i++) begin
      send_good();
      chk("relock_err_pulse", 32'(err_pulse), 32'd0);
      chk("relock_sync_loss", 32'(sync_loss), 32'd0);
      chk("relock_locked", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("relock_err_count", 32'(err_count), 32'd5);

    // Reset while locked with errors, with en high and a bad sample.
    @(negedge clk);
    rst  = 1'b1;
    en   = 1'b1;
    word = 16'h0000;
    note = 6'h00;
    @(posedge clk);
    #1;
    chk("rst2_locked", 32'(locked), 32'd0);
    chk("rst2_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst2_sync_loss", 32'(sync_loss), 32'd0);
    chk("rst2_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // en toggling 1-0-1-0 with garbage on idle cycles.
    gw = 16'hA455;
    gn = 6'h2D;
    for (int i = 1; i <= 5; i++) begin
      send_good();
      chk("gap_locked_en", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
      send(1'b0, ~gw, ~gn);
      chk("gap_locked_idle", 32'(locked), (i == 5) ? 32'd1 : 32'd0);
      chk("gap_err_pulse", 32'(err_pulse), 32'd0);
    end
    chk("gap_err_count", 32'(err_count), 32'd0);

    // Saturation on the CNT_W=2, LOSS_THRESH=15 instance.
    do_reset();
    gw = 16'hA455;
    gn = 6'h2D;
    repeat (5) send_good();
    chk("sat_relock", 32'(s_locked), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 16'h0000, 6'h00);
      advance();
      chk("sat_err_count", 32'(s_err_count), (i < 3) ? 32'(i) : 32'd3);
      chk("sat_err_pulse", 32'(s_err_pulse), 32'd1);
      chk("sat_locked_hold", 32'(s_locked), 32'd1);
      if (i == 3) begin
        chk("main_loss_count", 32'(err_count), 32'd3);
        chk("main_loss_locked", 32'(locked), 32'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
